// File: rtl/ps2_pkg.sv
// ps2_pkg: shared definitions for the PS/2 paddle key decoder.
// FSM state encoding, Set-2 prefix/control bytes, key indices and the
// scancodes used by the Pong paddle/serve map.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_GOT_E0    = 3'd1,
    ST_GOT_F0    = 3'd2,
    ST_GOT_E0_F0 = 3'd3,
    ST_SKIP_E1   = 3'd4
  } ps2_state_e;

  // Sequence prefixes
  localparam logic [7:0] PFX_E0 = 8'hE0;
  localparam logic [7:0] PFX_F0 = 8'hF0;
  localparam logic [7:0] PFX_E1 = 8'hE1;

  // Keyboard-to-host control bytes that never form part of a key sequence
  localparam logic [7:0] CTL_ACK    = 8'hFA;
  localparam logic [7:0] CTL_BAT    = 8'hAA;
  localparam logic [7:0] CTL_RESEND = 8'hFE;
  localparam logic [7:0] CTL_ECHO   = 8'hEE;
  localparam logic [7:0] CTL_ERR0   = 8'h00;
  localparam logic [7:0] CTL_ERR1   = 8'hFF;

  // Pause sends E1 followed by seven more bytes that must be swallowed
  localparam logic [2:0] SKIP_E1_LEN = 3'd7;

  localparam int NUM_KEYS = 5;

  // Bit positions in key_held / key_press / key_release
  localparam logic [2:0] KEY_W     = 3'd0;
  localparam logic [2:0] KEY_S     = 3'd1;
  localparam logic [2:0] KEY_UP    = 3'd2;
  localparam logic [2:0] KEY_DOWN  = 3'd3;
  localparam logic [2:0] KEY_SPACE = 3'd4;

  // Set-2 scancodes (Up/Down only when E0-prefixed)
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;

  function automatic logic is_control_byte(input logic [7:0] b);
    logic r;
    case (b)
      CTL_ACK, CTL_BAT, CTL_RESEND, CTL_ECHO, CTL_ERR0, CTL_ERR1: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic is_prefix_byte(input logic [7:0] b);
    logic r;
    case (b)
      PFX_E0, PFX_F0, PFX_E1: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ps2_key_map.sv
// ps2_key_map: combinational lookup from (scancode, extended) to key index.
// Keypad 75/72 (non-extended) and extended 1D/1B/29 deliberately miss.
module ps2_key_map
  import ps2_pkg::*;
(
  input  logic [7:0] code,
  input  logic       ext,
  output logic       hit,
  output logic [2:0] index
);

  // Table lookup keyed on the extended flag plus the code byte
  always_comb begin
    hit   = 1'b0;
    index = 3'd0;
    case ({ext, code})
      {1'b0, SC_W}:     begin hit = 1'b1; index = KEY_W;     end
      {1'b0, SC_S}:     begin hit = 1'b1; index = KEY_S;     end
      {1'b0, SC_SPACE}: begin hit = 1'b1; index = KEY_SPACE; end
      {1'b1, SC_UP}:    begin hit = 1'b1; index = KEY_UP;    end
      {1'b1, SC_DOWN}:  begin hit = 1'b1; index = KEY_DOWN;  end
      default:          begin hit = 1'b0; index = 3'd0;      end
    endcase
  end

endmodule

// File: rtl/ps2_paddle_keys.sv
// ps2_paddle_keys: turns the PS2_Controller byte stream into held levels and
// press/release pulses for W, S, Up, Down, Space, and reports the last make.
// Optional macro KEY_TIMEOUT_EN: force-release all keys after TIMEOUT_CYCLES
// idle cycles, covering a lost break code.
module ps2_paddle_keys
  import ps2_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 75_000_000
)
(
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic [7:0]          received_data,
  input  logic                received_data_en,
  output logic [NUM_KEYS-1:0] key_held,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [7:0]          last_code,
  output logic                last_ext,
  output logic                code_valid
);

  // The idle counter is 27 bits wide and needs at least one idle cycle
  if (TIMEOUT_CYCLES < 32'd2 || TIMEOUT_CYCLES > 32'd134_217_728) begin : g_bad_timeout
    $error("ps2_paddle_keys: TIMEOUT_CYCLES out of range");
  end

  ps2_state_e          state_r;
  logic [2:0]          skip_cnt_r;
  logic                ctrl_s;
  logic                prefix_s;
  logic                ext_s;
  logic                make_s;
  logic                brk_s;
  logic                map_hit_s;
  logic [2:0]          map_idx_s;
  logic [NUM_KEYS-1:0] held_nxt_s;
  logic                timeout_hit_s;

  ps2_key_map u_key_map (
    .code  (received_data),
    .ext   (ext_s),
    .hit   (map_hit_s),
    .index (map_idx_s)
  );

  // Classify the current byte and decide whether it completes a make or break
  always_comb begin
    ctrl_s   = is_control_byte(received_data);
    prefix_s = is_prefix_byte(received_data);
    ext_s    = (state_r == ST_GOT_E0) || (state_r == ST_GOT_E0_F0);
    make_s   = 1'b0;
    brk_s    = 1'b0;
    if (received_data_en && !ctrl_s && !prefix_s) begin
      case (state_r)
        ST_IDLE, ST_GOT_E0:      make_s = 1'b1;
        ST_GOT_F0, ST_GOT_E0_F0: brk_s  = 1'b1;
        default: begin
          make_s = 1'b0;
          brk_s  = 1'b0;
        end
      endcase
    end else begin
      make_s = 1'b0;
      brk_s  = 1'b0;
    end
  end

  // Next held vector; a timeout overrides any key activity
  always_comb begin
    held_nxt_s = key_held;
    if (timeout_hit_s) begin
      held_nxt_s = {NUM_KEYS{1'b0}};
    end else if (map_hit_s && make_s) begin
      held_nxt_s[map_idx_s] = 1'b1;
    end else if (map_hit_s && brk_s) begin
      held_nxt_s[map_idx_s] = 1'b0;
    end else begin
      held_nxt_s = key_held;
    end
  end

`ifdef KEY_TIMEOUT_EN
  localparam logic [26:0] TO_LAST = 27'(TIMEOUT_CYCLES - 32'd1);

  logic [26:0] to_cnt_r;

  // Idle counter: cleared by any byte, saturates at TIMEOUT_CYCLES-1
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      to_cnt_r <= 27'd0;
    end else if (received_data_en) begin
      to_cnt_r <= 27'd0;
    end else if (to_cnt_r != TO_LAST) begin
      to_cnt_r <= to_cnt_r + 27'd1;
    end else begin
      to_cnt_r <= to_cnt_r;
    end
  end

  // Fires once, on the edge where the counter steps onto its last value
  assign timeout_hit_s = !received_data_en && (to_cnt_r == (TO_LAST - 27'd1));
`else
  assign timeout_hit_s = 1'b0;
`endif

  // Sequence FSM and registered outputs
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      skip_cnt_r  <= 3'd0;
      key_held    <= {NUM_KEYS{1'b0}};
      key_press   <= {NUM_KEYS{1'b0}};
      key_release <= {NUM_KEYS{1'b0}};
      last_code   <= 8'h00;
      last_ext    <= 1'b0;
      code_valid  <= 1'b0;
    end else begin
      key_held    <= held_nxt_s;
      key_press   <= held_nxt_s & ~key_held;
      key_release <= key_held & ~held_nxt_s;
      code_valid  <= make_s;
      if (make_s) begin
        last_code <= received_data;
        last_ext  <= ext_s;
      end

      if (timeout_hit_s) begin
        state_r    <= ST_IDLE;
        skip_cnt_r <= 3'd0;
      end else if (received_data_en) begin
        case (state_r)
          ST_IDLE: begin
            if (received_data == PFX_E0) begin
              state_r <= ST_GOT_E0;
            end else if (received_data == PFX_F0) begin
              state_r <= ST_GOT_F0;
            end else if (received_data == PFX_E1) begin
              state_r    <= ST_SKIP_E1;
              skip_cnt_r <= SKIP_E1_LEN;
            end else begin
              state_r <= ST_IDLE;
            end
          end
          ST_GOT_E0: begin
            if (received_data == PFX_F0) begin
              state_r <= ST_GOT_E0_F0;
            end else if (received_data == PFX_E0) begin
              state_r <= ST_GOT_E0;
            end else if (received_data == PFX_E1) begin
              state_r    <= ST_SKIP_E1;
              skip_cnt_r <= SKIP_E1_LEN;
            end else begin
              state_r <= ST_IDLE;
            end
          end
          ST_GOT_F0, ST_GOT_E0_F0: begin
            state_r <= ST_IDLE;
          end
          ST_SKIP_E1: begin
            skip_cnt_r <= skip_cnt_r - 3'd1;
            if (skip_cnt_r <= 3'd1) begin
              state_r <= ST_IDLE;
            end else begin
              state_r <= ST_SKIP_E1;
            end
          end
          default: begin
            state_r    <= ST_IDLE;
            skip_cnt_r <= 3'd0;
          end
        endcase
      end else begin
        state_r <= state_r;
      end
    end
  end

endmodule
